zap_ifetch_wb_master: RTL and testbench

Instruction-side Wishbone (classic) bus initiator that produces the instruction word, valid and instruction-abort signals consumed by the fetch stage. It also produces the code-stall signal that freezes the fetch stage.
- Fetches one word per request at the current PC and holds it until the pipeline accepts it.
- Converts bus errors and bus timeouts into instruction aborts.
- Discards in-flight fetches on a pipeline flush without violating the bus protocol.

---
 rtl/zap_ifetch_wb_master.sv | 168 ++++++++++++++++
 tb/tb_zap_ifetch_wb_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/zap_ifetch_wb_master.sv
// Instruction-side Wishbone classic initiator: fetches one word per request,
// holds it for the fetch stage, and turns bus errors/timeouts into aborts.
module zap_ifetch_wb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_ff,
  input  logic        i_cpsr_ff_t,
  input  logic        i_stall,
  input  logic        i_clear,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort,
  output logic        o_code_stall,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic          valid_q, valid_d;
  logic          abort_q, abort_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic          tmode_q, tmode_d;

  logic          timeout;
  logic          bus_done;
  logic          pc_bit0_unused;

  assign pc_bit0_unused = i_pc_ff[0];

  assign timeout  = (cnt_q == CNT_LAST);
  assign bus_done = i_wb_ack | i_wb_err | timeout;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    valid_d = valid_q;
    abort_d = abort_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tmode_d = tmode_q;

    case (state_q)
      S_IDLE: begin
        adr_d   = {i_pc_ff[31:2], 2'b00};
        sel_d   = '1;
        cyc_d   = 1'b1;
        half_d  = i_pc_ff[1];
        tmode_d = i_cpsr_ff_t;
        cnt_d   = '0;
        state_d = S_REQ;
      end

      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (i_clear) begin
          // Classic Wishbone cannot abandon a cycle, so a flush without a
          // response has to wait out the transfer in DRAIN.
          if (bus_done) begin
            cyc_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (i_wb_ack) begin
          cyc_d   = 1'b0;
          valid_d = 1'b1;
          abort_d = 1'b0;
          if (tmode_q) begin
            instr_d = {16'd0, half_q ? i_wb_dat[31:16] : i_wb_dat[15:0]};
          end else begin
            instr_d = i_wb_dat;
          end
          state_d = S_HOLD;
        end else if (i_wb_err || timeout) begin
          cyc_d   = 1'b0;
          valid_d = 1'b1;
          abort_d = 1'b1;
          instr_d = '0;
          state_d = S_HOLD;
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_done) begin
          cyc_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_HOLD: begin
        if (i_clear || !i_stall) begin
          valid_d = 1'b0;
          abort_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      instr_q <= '0;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      tmode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tmode_q <= tmode_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_valid       = valid_q;
  assign o_instr_abort = abort_q;
  assign o_code_stall  = (state_q != S_HOLD);
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = cyc_q;
  assign o_wb_we       = 1'b0;
  assign o_wb_sel      = sel_q;
  assign o_wb_adr      = adr_q;

endmodule

// File: tb/tb_zap_ifetch_wb_master.sv
// Transaction-level bench: each fetch is described by slave response kind,
// latency, flush point and stall length; expectations follow from those.
module tb_zap_ifetch_wb_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        tbit;
  logic        stall;
  logic        clr;
  logic [31:0] dat;
  logic        ack;
  logic        err;

  logic [31:0] instr;
  logic        valid;
  logic        iabort;
  logic        cstall;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  zap_ifetch_wb_master #(.TIMEOUT(TO)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_pc_ff       (pc),
    .i_cpsr_ff_t   (tbit),
    .i_stall       (stall),
    .i_clear       (clr),
    .o_instruction (instr),
    .o_valid       (valid),
    .o_instr_abort (iabort),
    .o_code_stall  (cstall),
    .o_wb_cyc      (cyc),
    .o_wb_stb      (stb),
    .o_wb_we       (we),
    .o_wb_sel      (sel),
    .o_wb_adr      (adr),
    .i_wb_dat      (dat),
    .i_wb_ack      (ack),
    .i_wb_err      (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a, input logic tm, input logic [31:0] d);
    if (!tm) return d;
    return (d >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
  endfunction

  function automatic logic rbit();
    return ($urandom & 1) != 0;
  endfunction

  // kind: 0 = slave acks at REQ cycle wt, 1 = slave errors at wt, 2 = silent.
  // clr_at: REQ cycle in which the flush arrives, -1 for none.
  task automatic do_fetch(input logic [31:0] f_pc, input logic f_t, input int kind,
                          input int wt, input int clr_at, input int stl,
                          input logic [31:0] f_dat, input bit rel_by_clear);
    int          e;
    bit          faulted;
    logic [31:0] ew;
    e       = (kind != 2 && wt <= TO - 1) ? wt : TO - 1;
    faulted = !(kind == 0 && wt <= TO - 1);
    pc    = f_pc;
    tbit  = f_t;
    clr   = 1'b0;
    stall = rbit();
    ack   = 1'b0;
    err   = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= e; k++) begin
      check_eq("req_cyc", {31'd0, cyc}, 32'd1);
      check_eq("req_stb", {31'd0, stb}, 32'd1);
      check_eq("req_we", {31'd0, we}, 32'd0);
      check_eq("req_adr", adr, f_pc & 32'hFFFF_FFFC);
      check_eq("req_sel", {28'd0, sel}, 32'hF);
      check_eq("req_cstall", {31'd0, cstall}, 32'd1);
      check_eq("req_valid", {31'd0, valid}, 32'd0);
      pc    = $urandom;
      tbit  = rbit();
      stall = rbit();
      ack   = (kind == 0 && k == wt);
      err   = (kind == 1 && k == wt) || (kind == 0 && k == wt && rbit());
      dat   = (k == wt) ? f_dat : $urandom;
      clr   = (clr_at >= 0) && (k == clr_at || (k > clr_at && rbit()));
      @(negedge clk);
    end
    ack = 1'b0;
    err = 1'b0;
    clr = 1'b0;
    if (clr_at >= 0) begin
      check_eq("flush_cyc", {31'd0, cyc}, 32'd0);
      check_eq("flush_valid", {31'd0, valid}, 32'd0);
      check_eq("flush_abort", {31'd0, iabort}, 32'd0);
      check_eq("flush_cstall", {31'd0, cstall}, 32'd1);
      return;
    end
    ew = faulted ? 32'd0 : exp_word(f_pc, f_t, f_dat);
    for (int j = 0; j <= stl; j++) begin
      check_eq("hold_valid", {31'd0, valid}, 32'd1);
      check_eq("hold_abort", {31'd0, iabort}, {31'd0, faulted});
      check_eq("hold_instr", instr, ew);
      check_eq("hold_cyc", {31'd0, cyc}, 32'd0);
      check_eq("hold_cstall", {31'd0, cstall}, 32'd0);
      ack = (kind == 2 && j == 0);
      dat = $urandom;
      if (j == stl) begin
        clr   = rel_by_clear;
        stall = rel_by_clear;
      end else begin
        clr   = 1'b0;
        stall = 1'b1;
      end
      @(negedge clk);
    end
    ack = 1'b0;
    clr = 1'b0;
    check_eq("rel_valid", {31'd0, valid}, 32'd0);
    check_eq("rel_abort", {31'd0, iabort}, 32'd0);
    check_eq("rel_cstall", {31'd0, cstall}, 32'd1);
    check_eq("rel_cyc", {31'd0, cyc}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    pc    = 32'd0;
    tbit  = 1'b0;
    stall = 1'b0;
    clr   = 1'b0;
    dat   = 32'd0;
    ack   = 1'b0;
    err   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_abort", {31'd0, iabort}, 32'd0);
    check_eq("rst_cstall", {31'd0, cstall}, 32'd1);
    check_eq("rst_cyc", {31'd0, cyc}, 32'd0);
    check_eq("rst_stb", {31'd0, stb}, 32'd0);
    check_eq("rst_sel", {28'd0, sel}, 32'd0);
    check_eq("rst_adr", adr, 32'd0);
    rst = 1'b0;

    do_fetch(32'h100, 1'b0, 0, 0, -1, 0, 32'hE3A0_0001, 1'b0);
    do_fetch(32'h102, 1'b1, 0, 1, -1, 1, 32'hBEEF_1234, 1'b0);
    do_fetch(32'h100, 1'b1, 0, 2, -1, 0, 32'hBEEF_1234, 1'b1);
    do_fetch(32'h200, 1'b0, 1, 2, -1, 0, 32'h1234_5678, 1'b0);
    do_fetch(32'h300, 1'b0, 2, 0, -1, 2, 32'h0, 1'b0);
    do_fetch(32'h400, 1'b0, 0, 3, 1, 0, 32'hCAFE_F00D, 1'b0);
    do_fetch(32'h500, 1'b0, 0, 0, -1, 0, 32'h0BAD_F00D, 1'b0);
    do_fetch(32'h600, 1'b0, 0, 1, -1, 5, 32'h5555_AAAA, 1'b0);
    do_fetch(32'h700, 1'b1, 0, 3, -1, 0, 32'h9876_5432, 1'b0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      int wt;
      int e;
      int ca;
      kind = int'($urandom_range(0, 2));
      wt   = int'($urandom_range(0, 5));
      e    = (kind != 2 && wt <= TO - 1) ? wt : TO - 1;
      ca   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, e)) : -1;
      do_fetch($urandom, rbit(), kind, wt, ca, int'($urandom_range(0, 3)), $urandom, rbit());
    end

    pc   = 32'h800;
    tbit = 1'b0;
    @(negedge clk);
    check_eq("mid_cyc_before", {31'd0, cyc}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_cyc", {31'd0, cyc}, 32'd0);
    check_eq("mid_rst_stb", {31'd0, stb}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, valid}, 32'd0);
    check_eq("mid_rst_adr", adr, 32'd0);
    check_eq("mid_rst_cstall", {31'd0, cstall}, 32'd1);
    rst = 1'b0;
    do_fetch(32'h904, 1'b0, 0, 1, -1, 0, 32'h1357_9BDF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
